// File: rtl/ddr_pkg.sv
// Shared HDR-DDR definitions: mode codes (common to TX and RX), token pattern and widths.
// The optional readback check in ddr_tx is enabled with `define DDR_TX_READBACK_CHECK_EN.
package ddr_pkg;

    localparam int DATA_W = 8;
    localparam int CRC_W  = 5;

    localparam logic [3:0] TOKEN = 4'hC;

    localparam logic [3:0] MODE_PREAMBLE_ZERO = 4'b0000;
    localparam logic [3:0] MODE_PREAMBLE_ONE  = 4'b0001;
    localparam logic [3:0] MODE_SERIAL_BYTE   = 4'b0011;
    localparam logic [3:0] MODE_TOKEN         = 4'b0101;
    localparam logic [3:0] MODE_PARITY        = 4'b0110;
    localparam logic [3:0] MODE_CRC_VALUE     = 4'b0111;
    // Never issued by the CCC FSM; used as the "no previous mode" marker.
    localparam logic [3:0] MODE_NONE          = 4'b1111;

    // Number of bits in a field; 0 marks a code that transmits nothing.
    function automatic logic [3:0] mode_len(input logic [3:0] mode);
        logic [3:0] len;
        len = 4'd0;
        case (mode)
            MODE_PREAMBLE_ZERO: len = 4'd1;
            MODE_PREAMBLE_ONE:  len = 4'd1;
            MODE_SERIAL_BYTE:   len = 4'd8;
            MODE_TOKEN:         len = 4'd4;
            MODE_PARITY:        len = 4'd2;
            MODE_CRC_VALUE:     len = 4'd5;
            default:            len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ddr_parity_gen.sv
// HDR-DDR parity pair for a 16-bit data word: P1 = XOR of odd bits, P0 = XOR of even bits inverted.
// Purely combinational so TX and RX can share it.
module ddr_parity_gen
    import ddr_pkg::*;
(
    input  logic [2*DATA_W-1:0] word,
    output logic [1:0]          parity
);

    assign parity[1] = ^(word & 16'hAAAA);
    assign parity[0] = ~(^(word & 16'h5555));

endmodule

// File: rtl/ddr_tx.sv
// HDR-DDR transmit serializer: one bit per SCL edge (both edges), MSB first, feeding bytes to the CRC engine.
// Define DDR_TX_READBACK_CHECK_EN to add the SDA readback comparison and its sticky error output.
module ddr_tx
    import ddr_pkg::*;
(
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_sclgen_scl_pos_edge,
    input  logic              i_sclgen_scl_neg_edge,
    input  logic              i_ddrccc_tx_en,
    input  logic [3:0]        i_ddrccc_tx_mode,
    input  logic [DATA_W-1:0] i_regf_tx_data,
    input  logic [CRC_W-1:0]  i_crc_value,
`ifdef DDR_TX_READBACK_CHECK_EN
    input  logic              i_sdahnd_rx_sda,
    output logic              o_ddrccc_tx_error,
`endif
    output logic              o_sdahnd_tx_sda,
    output logic              o_ddrccc_tx_mode_done,
    output logic              o_crc_en,
    output logic              o_crc_data_valid,
    output logic [DATA_W-1:0] o_crc_data_out
);

    logic                edge_seen;
    logic [3:0]          prev_mode;
    logic [2:0]          bit_cnt;
    logic [2:0]          bit_idx;
    logic [3:0]          field_len;
    logic                mode_active;
    logic                last_bit;
    logic                sda_next;
    logic [DATA_W-1:0]   byte_reg;
    logic [CRC_W-1:0]    crc_reg;
    logic [2*DATA_W-1:0] par_word;
    logic [1:0]          par_now;
    logic [1:0]          par_reg;
    logic                byte_num;
    logic                crc_hold;
    logic [3:0]          token_bits;

    assign edge_seen   = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign field_len   = mode_len(i_ddrccc_tx_mode);
    assign mode_active = i_ddrccc_tx_en && (field_len != 4'd0);
    // A mode that differs from the one seen at the previous edge starts its field from bit 0.
    assign bit_idx     = (i_ddrccc_tx_mode != prev_mode) ? 3'd0 : bit_cnt;
    assign last_bit    = mode_active && ({1'b0, bit_idx} == (field_len - 4'd1));
    assign token_bits  = TOKEN;

    ddr_parity_gen u_parity (
        .word   (par_word),
        .parity (par_now)
    );

    always_comb begin
        sda_next = 1'b1;
        case (i_ddrccc_tx_mode)
            MODE_PREAMBLE_ZERO: sda_next = 1'b0;
            MODE_PREAMBLE_ONE:  sda_next = 1'b1;
            MODE_SERIAL_BYTE:   sda_next = (bit_idx == 3'd0) ? i_regf_tx_data[7] : byte_reg[3'd7 - bit_idx];
            MODE_TOKEN:         sda_next = token_bits[2'd3 - bit_idx[1:0]];
            MODE_PARITY:        sda_next = (bit_idx == 3'd0) ? par_now[1] : par_reg[0];
            MODE_CRC_VALUE:     sda_next = (bit_idx == 3'd0) ? i_crc_value[4] : crc_reg[3'd4 - bit_idx];
            default:            sda_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            o_sdahnd_tx_sda       <= 1'b1;
            o_ddrccc_tx_mode_done <= 1'b0;
            o_crc_en              <= 1'b0;
            o_crc_data_valid      <= 1'b0;
            o_crc_data_out        <= '0;
            prev_mode             <= MODE_NONE;
            bit_cnt               <= 3'd0;
            byte_reg              <= '0;
            crc_reg               <= '0;
            par_word              <= '0;
            par_reg               <= 2'b00;
            byte_num              <= 1'b0;
            crc_hold              <= 1'b0;
`ifdef DDR_TX_READBACK_CHECK_EN
            o_ddrccc_tx_error     <= 1'b0;
`endif
        end else begin
            o_ddrccc_tx_mode_done <= 1'b0;
            o_crc_data_valid      <= 1'b0;
            // crc_hold keeps the CRC engine disabled from the cycle after the CRC5 field completes.
            o_crc_en <= i_ddrccc_tx_en &&
                        ((i_ddrccc_tx_mode == MODE_SERIAL_BYTE) ||
                         ((i_ddrccc_tx_mode == MODE_CRC_VALUE) && !crc_hold));
            if (!i_ddrccc_tx_en || (i_ddrccc_tx_mode != MODE_CRC_VALUE)) begin
                crc_hold <= 1'b0;
            end

            if (!i_ddrccc_tx_en) begin
                o_sdahnd_tx_sda   <= 1'b1;
                bit_cnt           <= 3'd0;
`ifdef DDR_TX_READBACK_CHECK_EN
                o_ddrccc_tx_error <= 1'b0;
`endif
            end else if (edge_seen) begin
                prev_mode       <= i_ddrccc_tx_mode;
                o_sdahnd_tx_sda <= sda_next;
`ifdef DDR_TX_READBACK_CHECK_EN
                if (mode_active && (i_sdahnd_rx_sda != o_sdahnd_tx_sda)) begin
                    o_ddrccc_tx_error <= 1'b1;
                end
`endif
                if (mode_active) begin
                    bit_cnt               <= last_bit ? 3'd0 : bit_idx + 3'd1;
                    o_ddrccc_tx_mode_done <= last_bit;
                    case (i_ddrccc_tx_mode)
                        MODE_PREAMBLE_ZERO, MODE_PREAMBLE_ONE: byte_num <= 1'b0;
                        MODE_SERIAL_BYTE: begin
                            if (bit_idx == 3'd0) begin
                                byte_reg <= i_regf_tx_data;
                            end
                            if (last_bit) begin
                                o_crc_data_valid <= 1'b1;
                                o_crc_data_out   <= byte_reg;
                                if (byte_num) begin
                                    par_word[7:0] <= byte_reg;
                                end else begin
                                    par_word[15:8] <= byte_reg;
                                end
                                byte_num <= ~byte_num;
                            end
                        end
                        MODE_PARITY: begin
                            if (bit_idx == 3'd0) begin
                                par_reg <= par_now;
                            end
                            if (last_bit) begin
                                byte_num <= 1'b0;
                            end
                        end
                        MODE_CRC_VALUE: begin
                            if (bit_idx == 3'd0) begin
                                crc_reg <= i_crc_value;
                            end
                            if (last_bit) begin
                                crc_hold <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    bit_cnt <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_tx.sv
// Directed scoreboard bench for ddr_tx: each edge pushes its expected {sda, done, valid, crc_en, byte} into a queue.
module tb_ddr_tx;
    import ddr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pos = 1'b0;
    logic       neg = 1'b0;
    logic       tx_en = 1'b0;
    logic [3:0] mode = MODE_NONE;
    logic [7:0] tx_data = 8'h00;
    logic [4:0] crc_value = 5'h00;
    logic       sda;
    logic       done;
    logic       crc_en;
    logic       crc_valid;
    logic [7:0] crc_data;
`ifdef DDR_TX_READBACK_CHECK_EN
    logic       force_bad = 1'b0;
    logic       rx_sda;
    logic       tx_error;
    assign rx_sda = force_bad ? 1'b0 : sda;
`endif

    ddr_tx dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst_n),
        .i_sclgen_scl_pos_edge (pos),
        .i_sclgen_scl_neg_edge (neg),
        .i_ddrccc_tx_en        (tx_en),
        .i_ddrccc_tx_mode      (mode),
        .i_regf_tx_data        (tx_data),
        .i_crc_value           (crc_value),
`ifdef DDR_TX_READBACK_CHECK_EN
        .i_sdahnd_rx_sda       (rx_sda),
        .o_ddrccc_tx_error     (tx_error),
`endif
        .o_sdahnd_tx_sda       (sda),
        .o_ddrccc_tx_mode_done (done),
        .o_crc_en              (crc_en),
        .o_crc_data_valid      (crc_valid),
        .o_crc_data_out        (crc_data)
    );

    always #5 clk = ~clk;

    // Entry layout: {sda, done, crc_data_valid, crc_en, crc_data_out (only meaningful when valid)}
    logic [11:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [11:0] observed();
        return {sda, done, crc_valid, crc_en, crc_valid ? crc_data : 8'h00};
    endfunction

    // which: 0 = rising strobe, 1 = falling strobe, 2 = both in the same cycle
    task automatic edge_pulse(input logic [11:0] want, input int which);
        exp_q.push_back(want);
        @(negedge clk);
        pos = (which != 1);
        neg = (which != 0);
        @(negedge clk);
        pos = 1'b0;
        neg = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Sends n edges in mode m; bits holds the expected SDA sequence right-aligned, first bit at [n-1].
    task automatic send_field(input logic [3:0] m, input logic [15:0] bits, input int n,
                              input logic exp_crc_en, input logic done_last,
                              input logic valid_last, input logic [7:0] vbyte);
        mode = m;
        for (int k = 0; k < n; k++) begin
            logic last;
            last = (k == n - 1);
            edge_pulse({bits[n-1-k], last & done_last, last & valid_last, exp_crc_en,
                        (last & valid_last) ? vbyte : 8'h00}, k % 3);
        end
    endtask

    initial begin : monitor
        logic [11:0] want;
        forever begin
            @(posedge clk);
            if (rst_n && (pos || neg)) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL edge_unexpected: got %h, expected no edge", observed());
                end else begin
                    want = exp_q.pop_front();
                    check("edge", observed(), want);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_bad++;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : stimulus
        #12;
        check("reset_outputs", {sda, done, crc_valid, crc_en, crc_data}, 12'h800);
`ifdef DDR_TX_READBACK_CHECK_EN
        check("reset_error", {11'h0, tx_error}, 12'h000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tx_en = 1'b1;
        @(negedge clk);

        // Preambles, one edge each
        send_field(MODE_PREAMBLE_ONE,  16'h0001, 1, 1'b0, 1'b1, 1'b0, 8'h00);
        send_field(MODE_PREAMBLE_ZERO, 16'h0000, 1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Two bytes back-to-back then the parity pair for word 0xA53C (P1=0, P0=1)
        tx_data = 8'hA5;
        send_field(MODE_SERIAL_BYTE, 16'h00A5, 8, 1'b1, 1'b1, 1'b1, 8'hA5);
        tx_data = 8'h3C;
        send_field(MODE_SERIAL_BYTE, 16'h003C, 8, 1'b1, 1'b1, 1'b1, 8'h3C);
        send_field(MODE_PARITY, 16'h0001, 2, 1'b0, 1'b1, 1'b0, 8'h00);

        // Token then CRC5 = 5'h13
        send_field(MODE_TOKEN, 16'h000C, 4, 1'b0, 1'b1, 1'b0, 8'h00);
        crc_value = 5'h13;
        send_field(MODE_CRC_VALUE, 16'h0013, 5, 1'b1, 1'b1, 1'b0, 8'h00);
        check("crc_en_after_done", {11'h0, crc_en}, 12'h000);

        // Unknown mode code idles SDA high without done
        send_field(MODE_PREAMBLE_ZERO, 16'h0000, 1, 1'b0, 1'b1, 1'b0, 8'h00);
        send_field(4'b1010, 16'h0001, 1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Abandoned byte after 3 edges, token restarts at bit 0
        tx_data = 8'h0F;
        send_field(MODE_SERIAL_BYTE, 16'h0000, 3, 1'b1, 1'b0, 1'b0, 8'h00);
        send_field(MODE_TOKEN, 16'h000C, 4, 1'b0, 1'b1, 1'b0, 8'h00);

        // Disabled block: SDA high, nothing counted
        tx_en = 1'b0;
        send_field(MODE_SERIAL_BYTE, 16'h0001, 1, 1'b0, 1'b0, 1'b0, 8'h00);
        tx_en = 1'b1;

        // Reset mid-byte, then a full byte restarting at bit 7
        tx_data = 8'hA5;
        send_field(MODE_SERIAL_BYTE, 16'h0005, 3, 1'b1, 1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_byte", {sda, done, crc_valid, crc_en, crc_data}, 12'h800);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_data = 8'h5A;
        send_field(MODE_SERIAL_BYTE, 16'h005A, 8, 1'b1, 1'b1, 1'b1, 8'h5A);

`ifdef DDR_TX_READBACK_CHECK_EN
        send_field(MODE_PREAMBLE_ONE, 16'h0001, 1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("readback_clean", {11'h0, tx_error}, 12'h000);
        force_bad = 1'b1;
        send_field(MODE_PREAMBLE_ONE, 16'h0001, 1, 1'b0, 1'b1, 1'b0, 8'h00);
        force_bad = 1'b0;
        check("readback_error_set", {11'h0, tx_error}, 12'h001);
        send_field(MODE_PREAMBLE_ONE, 16'h0001, 1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("readback_error_sticky", {11'h0, tx_error}, 12'h001);
        tx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("readback_error_clear", {11'h0, tx_error}, 12'h000);
        tx_en = 1'b1;
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected edges left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
